// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path: digit width and
// active-low segment patterns (bit6 = a ... bit0 = g).
package seg_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [SEG_W-1:0] SEG_DIGITS [0:9] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100   // 9
    };

endpackage

// File: rtl/digit_seg_lut.sv
// Combinational BCD to active-low seven-segment decode; 10..15 show blank.
module digit_seg_lut
    import seg_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd < 4'd10) seg = SEG_DIGITS[bcd];
    end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed common-anode seven-segment driver. New digits are staged in
// a shadow register and promoted to the display register only at frame start.
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        blank_lz,
    output logic [NUM_DIGITS-1:0]       an,
    output logic [SEG_W-1:0]            seg,
    output logic                        dp,
    output logic                        frame_start
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    typedef struct packed {
        logic [NUM_DIGITS-1:0][BCD_W-1:0] digits;
        logic [NUM_DIGITS-1:0]            dps;
        logic                             blz;
    } disp_t;

    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx, idx_nxt;
    disp_t            shadow_q, disp_q, in_val, disp_nxt;
    logic             tick, wrap;
    logic [BCD_W-1:0] digit_sel;
    logic [SEG_W-1:0] lut_seg;
    logic             upper_zero, lz_blank;

    assign in_val = {bcd_in, dp_in, blank_lz};
    assign tick   = (cnt == CNT_MAX);
    assign wrap   = tick && (idx == IDX_MAX);

    // Outputs are computed from the post-tick index and display contents so that
    // a load on the frame-start tick bypasses straight to the first digit.
    always_comb begin
        idx_nxt  = idx;
        disp_nxt = disp_q;
        if (tick) idx_nxt = wrap ? '0 : idx + 1'b1;
        if (wrap) disp_nxt = load ? in_val : shadow_q;
    end

    assign digit_sel = disp_nxt.digits[idx_nxt];

    always_comb begin
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (k >= int'(idx_nxt) && disp_nxt.digits[k] != '0) upper_zero = 1'b0;
        lz_blank = disp_nxt.blz && (idx_nxt != '0) && upper_zero;
    end

    digit_seg_lut u_lut (
        .bcd (digit_sel),
        .seg (lut_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= IDX_MAX;
            shadow_q    <= '0;
            disp_q      <= '0;
            an          <= '1;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            cnt         <= tick ? '0 : cnt + 1'b1;
            idx         <= idx_nxt;
            disp_q      <= disp_nxt;
            frame_start <= wrap;
            if (load) shadow_q <= in_val;
            if (tick) begin
                an  <= ~(NUM_DIGITS'(1) << idx_nxt);
                seg <= lz_blank ? SEG_BLANK : lut_seg;
                dp  <= ~disp_nxt.dps[idx_nxt];
            end
        end
    end

endmodule
